// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if
// Bundles the keypad matrix and press-pulse signals of the door-lock
// keypad front end.
//   COL_N    : matrix columns, active-low, asynchronous to the clock
//   ROW_N    : matrix row drive, active-low, one-cold
//   BUTTON   : one-hot digit press pulse, bit n = digit n
//   STAR     : '*' press pulse
//   HASH     : '#' press pulse
//   KEY_HELD : high from accepted press until accepted release
// master = scanner side, slave = matrix / lock side.
interface keypad_scanner_if;
    logic [2:0] COL_N;
    logic [3:0] ROW_N;
    logic [9:0] BUTTON;
    logic       STAR;
    logic       HASH;
    logic       KEY_HELD;

    modport master (
        input  COL_N,
        output ROW_N,
        output BUTTON,
        output STAR,
        output HASH,
        output KEY_HELD
    );

    modport slave (
        output COL_N,
        input  ROW_N,
        input  BUTTON,
        input  STAR,
        input  HASH,
        input  KEY_HELD
    );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x3 membrane keypad (1-9, *, 0, #), synchronises the columns,
// debounces whole scan frames and emits one single-cycle pulse per press.
//   CLK   : system clock, rising edge
//   RESET : asynchronous active-high reset
//   kp    : keypad_scanner_if.master (COL_N in; ROW_N, BUTTON, STAR, HASH,
//           KEY_HELD out, all registered)
// Key index within the 12-bit frame vector is row*3 + col.
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 5
) (
    input  logic              CLK,
    input  logic              RESET,
    keypad_scanner_if.master  kp
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] CNT_LAST  = DW'(DEBOUNCE_SCANS - 1);
    localparam logic [DW-1:0] CNT_FULL  = DW'(DEBOUNCE_SCANS);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PRESS_DB = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [1:0] ST_REL_DB   = 2'd3;

    logic [2:0]    col_meta_q, col_sync_q;
    logic [CW-1:0] slot_q, slot_d;
    logic [1:0]    row_q, row_d;
    logic [3:0]    row_n_q, row_n_d;
    logic [11:0]   frame_q, frame_d, frame_cur_s;
    logic [1:0]    state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [3:0]    cand_q, cand_d;
    logic          held_q, held_d;
    logic [9:0]    button_q, button_d;
    logic          star_q, star_d, hash_q, hash_d;

    logic          sample_s, frame_done_s, fire_s;
    logic [2:0]    keys_s;
    logic [3:0]    n_keys_s, code_s;

    // Slot/row sequencing and accumulation of column samples into the frame.
    always_comb begin
        sample_s     = (slot_q == SLOT_LAST);
        frame_done_s = sample_s && (row_q == 2'd3);
        keys_s       = ~col_sync_q;
        frame_cur_s  = frame_q;
        if (sample_s) begin
            slot_d = '0;
            row_d  = row_q + 2'd1;
            case (row_q)
                2'd0:    frame_cur_s[2:0]  = keys_s;
                2'd1:    frame_cur_s[5:3]  = keys_s;
                2'd2:    frame_cur_s[8:6]  = keys_s;
                2'd3:    frame_cur_s[11:9] = keys_s;
                default: frame_cur_s       = frame_q;
            endcase
        end else begin
            slot_d = slot_q + CW'(1);
            row_d  = row_q;
        end
        frame_d = frame_done_s ? 12'd0 : frame_cur_s;
        row_n_d = ~(4'b0001 << row_d);
    end

    // Classify the completed frame: key count and index of the (single) key.
    always_comb begin
        n_keys_s = 4'd0;
        code_s   = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (frame_cur_s[i]) begin
                n_keys_s = n_keys_s + 4'd1;
                code_s   = 4'(i);
            end else begin
                n_keys_s = n_keys_s;
            end
        end
    end

    // Frame-level debounce FSM; only moves on frame_done.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        held_d  = held_q;
        fire_s  = 1'b0;
        if (frame_done_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (n_keys_s == 4'd1) begin
                        state_d = ST_PRESS_DB;
                        cand_d  = code_s;
                        cnt_d   = DW'(1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PRESS_DB: begin
                    if ((n_keys_s == 4'd1) && (code_s == cand_q)) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_HELD;
                            cnt_d   = CNT_FULL;
                            held_d  = 1'b1;
                            fire_s  = 1'b1;
                        end else begin
                            cnt_d   = cnt_q + DW'(1);
                        end
                    end else begin
                        // A different key must start over from IDLE.
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_HELD: begin
                    if (n_keys_s == 4'd0) begin
                        state_d = ST_REL_DB;
                        cnt_d   = DW'(1);
                    end else begin
                        state_d = ST_HELD;
                    end
                end
                ST_REL_DB: begin
                    if (n_keys_s == 4'd0) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                            held_d  = 1'b0;
                        end else begin
                            cnt_d   = cnt_q + DW'(1);
                        end
                    end else begin
                        state_d = ST_HELD;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Map the accepted candidate onto the 12 one-hot pulse outputs.
    always_comb begin
        button_d = 10'd0;
        star_d   = 1'b0;
        hash_d   = 1'b0;
        if (fire_s) begin
            case (cand_q)
                4'd9:    star_d   = 1'b1;
                4'd10:   button_d = 10'b00_0000_0001;
                4'd11:   hash_d   = 1'b1;
                default: begin
                    // Indices 0..8 are digits 1..9.
                    if (cand_q < 4'd9) begin
                        button_d = 10'b00_0000_0010 << cand_q;
                    end else begin
                        button_d = 10'd0;
                    end
                end
            endcase
        end else begin
            button_d = 10'd0;
        end
    end

    // State registers, column synchroniser and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            col_meta_q <= 3'b111;
            col_sync_q <= 3'b111;
            slot_q     <= '0;
            row_q      <= 2'd0;
            row_n_q    <= 4'b1110;
            frame_q    <= 12'd0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cand_q     <= 4'd0;
            held_q     <= 1'b0;
            button_q   <= 10'd0;
            star_q     <= 1'b0;
            hash_q     <= 1'b0;
        end else begin
            col_meta_q <= kp.COL_N;
            col_sync_q <= col_meta_q;
            slot_q     <= slot_d;
            row_q      <= row_d;
            row_n_q    <= row_n_d;
            frame_q    <= frame_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cand_q     <= cand_d;
            held_q     <= held_d;
            button_q   <= button_d;
            star_q     <= star_d;
            hash_q     <= hash_d;
        end
    end

    assign kp.ROW_N    = row_n_q;
    assign kp.BUTTON   = button_q;
    assign kp.STAR     = star_q;
    assign kp.HASH     = hash_q;
    assign kp.KEY_HELD = held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
// Drives a modelled 4x3 key matrix (keys changed only at frame starts),
// predicts outputs with a frame-level reference model and checks every cycle.
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DB = 3;
    localparam int FRAME = 4 * SD;

    logic        clk;
    logic        rst;
    logic [11:0] keys;

    int n_cmp;
    int n_bad;

    // reference model state (frame level)
    int   m_st;
    int   m_cnt;
    int   m_cand;
    logic m_held;

    keypad_scanner_if kif ();

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .CLK   (clk),
        .RESET (rst),
        .kp    (kif)
    );

    // Physical matrix: a pressed key pulls its column low while its row is driven.
    function automatic logic [2:0] matrix_cols(input logic [11:0] k, input logic [3:0] rn);
        logic [2:0] c;
        c = 3'b111;
        for (int r = 0; r < 4; r++)
            for (int cc = 0; cc < 3; cc++)
                if (!rn[r] && k[r*3+cc]) c[cc] = 1'b0;
        return c;
    endfunction

    assign kif.COL_N = matrix_cols(keys, kif.ROW_N);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {BUTTON, STAR, HASH} for a key at matrix position idx.
    function automatic logic [11:0] key_outputs(input int idx);
        string lbl;
        byte   ch;
        logic [11:0] v;
        lbl = "123456789*0#";
        v   = 12'd0;
        ch  = lbl[idx];
        if (ch == 8'h2A)      v[1] = 1'b1;
        else if (ch == 8'h23) v[0] = 1'b1;
        else                  v[2 + int'(ch - 8'h30)] = 1'b1;
        return v;
    endfunction

    function automatic logic [11:0] one_key(input int idx);
        logic [11:0] v;
        v = 12'd0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_cand = 0; m_held = 1'b0;
    endtask

    // Apply the debounce rules to one complete frame's key set.
    task automatic model_frame(input logic [11:0] k, output logic [11:0] pulse);
        int n, code;
        n = 0; code = 0; pulse = 12'd0;
        for (int i = 0; i < 12; i++) if (k[i]) begin n++; code = i; end
        case (m_st)
            0: if (n == 1) begin m_st = 1; m_cand = code; m_cnt = 1; end
            1: if (n == 1 && code == m_cand) begin
                   m_cnt++;
                   if (m_cnt == DB) begin m_st = 2; m_held = 1'b1; pulse = key_outputs(code); end
               end else begin m_st = 0; m_cnt = 0; end
            2: if (n == 0) begin m_st = 3; m_cnt = 1; end
            3: if (n == 0) begin
                   m_cnt++;
                   if (m_cnt == DB) begin m_st = 0; m_cnt = 0; m_held = 1'b0; end
               end else begin m_st = 2; m_cnt = 0; end
            default: m_st = 0;
        endcase
    endtask

    task automatic check(input string tag, input logic [11:0] pulse, input logic held, input logic [3:0] rn);
        logic [16:0] obs, exp;
        obs = {kif.BUTTON, kif.STAR, kif.HASH, kif.KEY_HELD, kif.ROW_N};
        exp = {pulse, held, rn};
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s t=%0t: observed %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // Called at the negedge of a frame's first cycle; runs the whole frame.
    task automatic run_frame(input string tag, input logic [11:0] k);
        logic [11:0] pulse;
        int c;
        keys = k;
        for (int j = 1; j <= FRAME; j++) begin
            @(posedge clk);
            @(negedge clk);
            c = j % FRAME;
            pulse = 12'd0;
            if (j == FRAME) model_frame(k, pulse);
            check(tag, pulse, m_held, ~(4'b0001 << (c / SD)));
        end
    endtask

    task automatic run_frames(input string tag, input logic [11:0] k, input int n);
        for (int i = 0; i < n; i++) run_frame(tag, k);
    endtask

    initial begin
        logic [11:0] pat;
        int sel, nf;
        n_cmp = 0; n_bad = 0;
        keys = 12'd0;
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_state", 12'd0, 1'b0, 4'b1110);

        // clean press of '5', then held for 20 frames
        keys = one_key(4);
        rst = 1'b0;
        run_frames("press_5", one_key(4), DB);
        run_frames("hold_5", one_key(4), 20);
        // release debounce, then '#'
        run_frames("release_5", 12'd0, DB + 1);
        run_frames("press_hash", one_key(11), DB + 1);
        run_frames("release_hash", 12'd0, DB + 1);
        // bounce on '*'
        run_frames("bounce_star", one_key(9), 2);
        run_frames("bounce_gap", 12'd0, 1);
        run_frames("bounce_star", one_key(9), 2);
        run_frames("bounce_rel", 12'd0, DB + 1);
        // ghost / multi: '1' + '9'
        run_frames("multi_1_9", one_key(0) | one_key(8), 10);
        run_frames("multi_rel", 12'd0, DB);
        // rollover '2' -> '2'+'3' -> '3' -> release -> '3'
        run_frames("roll_2", one_key(1), DB + 1);
        run_frames("roll_2_3", one_key(1) | one_key(2), 4);
        run_frames("roll_3", one_key(2), 4);
        run_frames("roll_rel", 12'd0, DB + 1);
        run_frames("roll_3_again", one_key(2), DB + 1);
        run_frames("roll_rel2", 12'd0, DB + 1);

        // async reset during PRESS_DB with cnt=2
        run_frames("pre_reset_7", one_key(6), 2);
        for (int j = 1; j <= 5; j++) begin
            @(posedge clk);
            @(negedge clk);
            check("pre_reset_7", 12'd0, m_held, ~(4'b0001 << (j / SD)));
        end
        rst = 1'b1;
        #1;
        check("async_reset", 12'd0, 1'b0, 4'b1110);
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_hold", 12'd0, 1'b0, 4'b1110);
        rst = 1'b0;
        run_frames("after_reset_7", one_key(6), DB + 1);
        run_frames("after_reset_rel", 12'd0, DB + 1);

        // randomized patterns held for random frame counts
        pat = 12'd0;
        for (int p = 0; p < 60; p++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 3)      pat = 12'd0;
            else if (sel <= 7) pat = one_key($urandom_range(0, 11));
            else if (sel == 8) pat = one_key($urandom_range(0, 11)) | one_key($urandom_range(0, 11));
            else               pat = pat;
            nf = $urandom_range(1, 5);
            run_frames("random", pat, nf);
        end
        run_frames("final_rel", 12'd0, DB + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Front-end stage of the door-lock keypad. Scans a 4x3 membrane matrix (1-9, *, 0, #), synchronises and debounces it, and emits single-cycle press pulses on BUTTON[9:0], STAR and HASH.
- Those pulses feed the lock top-level's keypad inputs directly.
- Guarantees: one pulse per physical press, no bounce or ghost pulses, and nothing emitted while a key is held.

Parameters:
- SCAN_DIV, 50000: CLK cycles per row slot. Minimum 4. Counter width is $clog2(SCAN_DIV).
- DEBOUNCE_SCANS, 5: consecutive identical frames required to accept a press or a release. Minimum 2.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RESET  input  1  asynchronous, active-high reset.
- COL_N  input  3  matrix columns, active-low, pulled high externally, asynchronous to CLK.
- ROW_N  output  4  matrix row drive, active-low, exactly one bit low at any time.
- BUTTON  output  10  one-hot press pulse; bit n = digit n.
- STAR  output  1  '*' press pulse.
- HASH  output  1  '#' press pulse.
- KEY_HELD  output  1  high from the accepted press until the accepted release.

Behaviour:
- Reset (asynchronous) values:
  - ROW_N=4'b1110; BUTTON=0, STAR=0, HASH=0, KEY_HELD=0.
  - FSM=IDLE; slot counter, row index and debounce count = 0.
  - Frame accumulator cleared; both column synchroniser stages = 3'b111.
- Key map as [row][col]:
  - row0: 1,2,3
  - row1: 4,5,6
  - row2: 7,8,9
  - row3: *,0,#
- Column synchronisation: 2-flop synchroniser on COL_N. Key detected = synchronised column bit low.
- Scan:
  - Slot counter runs 0..SCAN_DIV-1; row index advances 0->1->2->3->0 on slot wrap.
  - ROW_N = ~(1<<row).
  - Columns are sampled on the last cycle of each slot (count==SCAN_DIV-1) into a 12-bit frame vector.
  - The row3 sample cycle asserts internal frame_done for 1 cycle. The frame vector is classified as NONE / SINGLE(code) / MULTI, then cleared.
- FSM, evaluated only on frame_done:
  - IDLE: SINGLE -> PRESS_DB, cand=code, cnt=1. NONE or MULTI -> stay.
  - PRESS_DB:
    - SINGLE with code==cand -> cnt+1. If cnt+1==DEBOUNCE_SCANS -> HELD, fire pulse, KEY_HELD<=1.
    - Anything else -> IDLE, cnt=0. A different single key does not restart as the new candidate; it must be seen again from IDLE.
  - HELD:
    - NONE -> REL_DB, cnt=1.
    - SINGLE or MULTI -> stay. Extra keys and rollover are ignored; no pulse.
  - REL_DB:
    - NONE -> cnt+1. If cnt+1==DEBOUNCE_SCANS -> IDLE, KEY_HELD<=0.
    - Any key -> HELD, cnt=0.
- Output pulse:
  - Registered, high exactly 1 CLK cycle, on the cycle after the accepting frame_done.
  - Exactly one of the 12 output bits is set; otherwise all outputs are 0.
- Press latency: for a key stable before a frame starts, pulse occurs DEBOUNCE_SCANS*4*SCAN_DIV cycles after that frame's first cycle, +1 cycle.
- KEY_HELD rises in the same cycle as the pulse and falls 1 cycle after the accepting release frame_done.
- Reset mid-operation: immediate return to the reset state. A key still held after reset is treated as a fresh press and pulses once after debounce.
- Wrap-around: slot, row and debounce counters never overflow; cnt saturates at DEBOUNCE_SCANS.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3, frame = 16 cycles):
- Clean press: hold '5' (row1/col1 low when ROW_N=1101) from cycle 0 after reset.
  - BUTTON=10'b0000100000 for exactly 1 cycle at cycle 49.
  - KEY_HELD=1 from cycle 49.
  - No further pulse while held for 20 frames.
- Release debounce: after the clean press, release key at a frame start.
  - KEY_HELD falls after 3 NONE frames.
  - Re-press of '#' gives HASH=1 for 1 cycle; BUTTON and STAR stay 0.
- Bounce: press '*' for 2 frames, release 1 frame, press 2 frames, release.
  - STAR never asserts; FSM returns to IDLE.
- Ghost / multi: hold '1' and '9' together for 10 frames.
  - No output pulse; KEY_HELD=0.
- Rollover: hold '2' until pulse, then also press '3', then release '2'.
  - Only BUTTON[2] pulses once; no BUTTON[3] pulse until all keys are released and '3' is pressed again.
- Async reset mid-debounce: assert RESET during PRESS_DB cnt=2.
  - Outputs 0 and ROW_N=1110 immediately.
  - Key still held: single pulse 3 frames after reset release.
